// File: rtl/neuron_accumulator.sv
// One neuron evaluation: bias plus N_INPUTS signed products, then ReLU,
// arithmetic right shift and saturation to an unsigned 10-bit activation.
module neuron_accumulator #(
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 26,
  parameter int SHIFT    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] bias,
  input  logic        prod_valid,
  input  logic [19:0] prod,
  output logic        prod_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_val,
  output logic        out_sat,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] MAX_Q = ACC_W'(1023);

  typedef enum logic [1:0] {IDLE, ACCUM, ACTIVATE, DONE} state_t;

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic signed [ACC_W-1:0]  bias_ext, prod_ext, shifted;
  logic                     acc_neg, act_sat;
  logic [9:0]               act_val;

  assign state_dbg = state;

  // Handshakes: a word moves on any rising edge where valid & ready are both
  // high; a valid producer holds its data stable until that edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    prod_ready = (state == ACCUM);
    busy       = (state != IDLE);
    unique case (state)
      IDLE:     if (start) state_nxt = ACCUM;
      ACCUM:    if (prod_valid && count == LAST_CNT) state_nxt = ACTIVATE;
      ACTIVATE: state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign bias_ext = {{(ACC_W-20){bias[19]}}, bias};
  assign prod_ext = {{(ACC_W-20){prod[19]}}, prod};

  // ReLU first, so the shift only ever sees a non-negative accumulator.
  assign acc_neg = acc[ACC_W-1];
  assign shifted = acc >>> SHIFT;
  assign act_sat = !acc_neg && (shifted > MAX_Q);
  assign act_val = acc_neg ? 10'd0 : (act_sat ? 10'd1023 : shifted[9:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_val   <= '0;
      out_sat   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= bias_ext;
            count <= '0;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc   <= acc + prod_ext;
            count <= count + CNT_W'(1);
          end
        end
        ACTIVATE: begin
          out_val   <= act_val;
          out_sat   <= act_sat;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: two instances (SHIFT=0 and SHIFT=9, N_INPUTS=4)
// share one stimulus stream; results are checked against a scoreboard model.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, prod_valid, out_ready;
  logic [19:0] bias, prod;

  logic       prod_ready0, out_valid0, out_sat0, busy0;
  logic [9:0] out_val0;
  logic [1:0] state_dbg0;
  logic       prod_ready9, out_valid9, out_sat9, busy9;
  logic [9:0] out_val9;
  logic [1:0] state_dbg9;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp0_q[$];
  logic [10:0] exp9_q[$];

  logic signed [19:0] cur_p[4];
  int                 cur_g[4];

  neuron_accumulator #(.N_INPUTS(4), .ACC_W(26), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_val(out_val0),
    .out_sat(out_sat0), .busy(busy0), .state_dbg(state_dbg0)
  );

  neuron_accumulator #(.N_INPUTS(4), .ACC_W(26), .SHIFT(9)) u9 (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready9),
    .out_valid(out_valid9), .out_ready(out_ready), .out_val(out_val9),
    .out_sat(out_sat9), .busy(busy9), .state_dbg(state_dbg9)
  );

  always #5 clk = ~clk;

  // Expected {sat, value} straight from the arithmetic rules.
  function automatic logic [10:0] model(input longint total, input int sh);
    longint q;
    if (total < 0) return 11'd0;
    q = total >>> sh;
    if (q > 1023) return {1'b1, 10'd1023};
    return {1'b0, q[9:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid0) begin
      if (exp0_q.size() == 0) check("u0_unexpected_valid", 32'd1, 32'd0);
      else check("u0_result", {21'd0, out_sat0, out_val0}, {21'd0, exp0_q[0]});
    end
    if (!rst && out_valid9) begin
      if (exp9_q.size() == 0) check("u9_unexpected_valid", 32'd1, 32'd0);
      else check("u9_result", {21'd0, out_sat9, out_val9}, {21'd0, exp9_q[0]});
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid0 && out_ready && exp0_q.size() > 0) void'(exp0_q.pop_front());
    if (!rst && out_valid9 && out_ready && exp9_q.size() > 0) void'(exp9_q.pop_front());
  end

  // Full evaluation using cur_p/cur_g; called and returns on a falling edge.
  task automatic run_eval(input logic signed [19:0] b, input int hold,
                          input bit start_hold, input int lit0, input int lit9);
    longint sum;
    start      = 1'b1;
    bias       = b;
    prod_valid = 1'b1;
    prod       = 20'(32'd77777);
    tick();
    start = 1'b0;
    bias  = 20'($urandom_range(0, 1048575));
    check("busy_after_start", {31'd0, busy0}, 32'd1);
    check("prod_ready_accum", {31'd0, prod_ready0}, 32'd1);
    sum = longint'(b);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < cur_g[i]; g++) begin
        prod_valid = 1'b0;
        prod       = 20'($urandom_range(0, 1048575));
        tick();
      end
      prod_valid = 1'b1;
      prod       = cur_p[i];
      sum += longint'(cur_p[i]);
      if (i == 3) begin
        check("model_pin_s0", {21'd0, model(sum, 0)}, lit0);
        check("model_pin_s9", {21'd0, model(sum, 9)}, lit9);
        exp0_q.push_back(model(sum, 0));
        exp9_q.push_back(model(sum, 9));
      end
      tick();
    end
    prod_valid = 1'b0;
    check("activate_no_valid", {31'd0, out_valid0}, 32'd0);
    check("activate_no_ready", {31'd0, prod_ready0}, 32'd0);
    tick();
    check("latency_valid_u0", {31'd0, out_valid0}, 32'd1);
    check("latency_valid_u9", {31'd0, out_valid9}, 32'd1);
    check("literal_u0", {21'd0, out_sat0, out_val0}, lit0);
    check("literal_u9", {21'd0, out_sat9, out_val9}, lit9);
    start = start_hold;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", {31'd0, out_valid0}, 32'd1);
      check("hold_busy", {31'd0, busy0}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handshake_clears_valid", {31'd0, out_valid0}, 32'd0);
    check("handshake_idle", {31'd0, busy0}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prod_valid = 1'b0; out_ready = 1'b0;
    bias = '0; prod = '0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check("rst_prod_ready", {31'd0, prod_ready0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_out_val", {22'd0, out_val0}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat0}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: mixed signs, back-to-back
    cur_p = '{20'sd100, 20'sd200, -20'sd50, 20'sd40}; cur_g = '{0, 0, 0, 0};
    run_eval(20'sd10, 0, 1'b0, 300, 0);

    // 2: worst-case negative sum, no wrap
    cur_p = '{-20'sd524288, -20'sd524288, -20'sd524288, -20'sd524288};
    run_eval(20'sd0, 1, 1'b0, 0, 0);

    // 3: saturation (2000000 >> 9 = 3906)
    cur_p = '{20'sd500000, 20'sd500000, 20'sd500000, 20'sd500000};
    run_eval(20'sd0, 0, 1'b0, 2047, 2047);

    // 4: valid pattern 1,0,0,1,0,1,1 and 5-cycle backpressure with start held
    cur_p = '{20'sd1, 20'sd1, 20'sd1, 20'sd1}; cur_g = '{0, 2, 1, 0};
    run_eval(20'sd0, 5, 1'b1, 4, 0);

    // 5: reset after 2 of 4 products, then a clean evaluation
    start = 1'b1; bias = 20'sd100; tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 20'sd7; tick();
    tick();
    prod_valid = 1'b0; rst = 1'b1; tick();
    check("abort_out_valid", {31'd0, out_valid0}, 32'd0);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_prod_ready", {31'd0, prod_ready0}, 32'd0);
    check("abort_out_val", {22'd0, out_val0}, 32'd0);
    rst = 1'b0;
    prod_valid = 1'b1; prod = 20'sd999; tick();
    check("idle_no_ready", {31'd0, prod_ready0}, 32'd0);
    cur_p = '{20'sd1, 20'sd1, 20'sd1, 20'sd1}; cur_g = '{0, 0, 0, 0};
    run_eval(20'sd5, 0, 1'b0, 9, 0);

    // 6: start held through DONE, then back-to-back evaluation
    cur_p = '{20'sd300, 20'sd300, 20'sd300, 20'sd300};
    run_eval(-20'sd20, 3, 1'b1, 2047, 2);
    cur_p = '{20'sd100000, 20'sd100000, 20'sd100000, 20'sd100000};
    run_eval(20'sd512, 0, 1'b0, 2047, 782);

    // exact-zero accumulator and a negative bias with a positive total
    cur_p = '{20'sd25, 20'sd25, 20'sd25, 20'sd25}; cur_g = '{1, 0, 3, 0};
    run_eval(-20'sd100, 2, 1'b0, 0, 0);
    cur_p = '{20'sd2000, -20'sd500, 20'sd300, 20'sd100}; cur_g = '{0, 1, 0, 2};
    run_eval(-20'sd1000, 1, 1'b0, 900, 1);

    tick();
    check("queue_drained_u0", exp0_q.size(), 32'd0);
    check("queue_drained_u9", exp9_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
